// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder.
// The signed-overflow output is enabled by defining RCA_OVERFLOW_EN.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;

    typedef logic [RCA_DEFAULT_WIDTH-1:0] operand_t;

endpackage : rca_pkg

// File: rtl/rca_full_adder.sv
// Single-bit full-adder cell used as one link of the ripple-carry chain.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (b & cin) | (a & cin);

endmodule : rca_full_adder

// File: rtl/ripple_carry_adder_4bit.sv
// Unsigned ripple-carry adder with a one-cycle registered copy of the result.
// Defining RCA_OVERFLOW_EN adds the Ovf/Ovf_q two's-complement overflow outputs.
module ripple_carry_adder_4bit
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
`ifdef RCA_OVERFLOW_EN
    output logic             Ovf,
    output logic             Ovf_q,
`endif
    output logic             out_valid
);

    logic [WIDTH:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .sum  (Sum[i]),
            .cout (c[i+1])
        );
    end

    assign Cout = c[WIDTH];

`ifdef RCA_OVERFLOW_EN
    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign Ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum_q     <= '0;
            Cout_q    <= 1'b0;
`ifdef RCA_OVERFLOW_EN
            Ovf_q     <= 1'b0;
`endif
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum_q  <= Sum;
                Cout_q <= Cout;
`ifdef RCA_OVERFLOW_EN
                Ovf_q  <= Ovf;
`endif
            end
        end
    end

endmodule : ripple_carry_adder_4bit

// File: tb/tb_ripple_carry_adder_4bit.sv
// Self-checking bench for ripple_carry_adder_4bit: arithmetic reference model,
// per-cycle compare process, and directed literal vectors.
module tb_ripple_carry_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       out_valid;
`ifdef RCA_OVERFLOW_EN
    logic       ovf;
    logic       ovf_q;
`endif

    int checks = 0;
    int errors = 0;

    ripple_carry_adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .in_valid  (in_valid),
        .Sum       (sum),
        .Cout      (cout),
        .Sum_q     (sum_q),
        .Cout_q    (cout_q),
`ifdef RCA_OVERFLOW_EN
        .Ovf       (ovf),
        .Ovf_q     (ovf_q),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_add(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int total;
        total = int'(x) + int'(y) + int'(ci);
        return 5'(total);
    endfunction

    function automatic logic ref_ovf(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return (s > 7) || (s < -8);
    endfunction

    // Reference model of the registered path
    logic [4:0] m_res_q;
    logic       m_ovf_q;
    logic       m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res_q <= '0;
            m_ovf_q <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                m_res_q <= ref_add(a, b, cin);
                m_ovf_q <= ref_ovf(a, b, cin);
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        e = ref_add(a, b, cin);
        chk("cmp_sum",     32'(sum),       32'(e[3:0]));
        chk("cmp_cout",    32'(cout),      32'(e[4]));
        chk("cmp_sum_q",   32'(sum_q),     32'(m_res_q[3:0]));
        chk("cmp_cout_q",  32'(cout_q),    32'(m_res_q[4]));
        chk("cmp_valid",   32'(out_valid), 32'(m_valid));
`ifdef RCA_OVERFLOW_EN
        chk("cmp_ovf",     32'(ovf),       32'(ref_ovf(a, b, cin)));
        chk("cmp_ovf_q",   32'(ovf_q),     32'(m_ovf_q));
`endif
    end

    task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic ci, input logic iv);
        @(posedge clk);
        #2;
        a = x; b = y; cin = ci; in_valid = iv;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; a = 4'd0; b = 4'd0; cin = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_sum_q",  32'(sum_q),     32'd0);
        chk("rst_cout_q", 32'(cout_q),    32'd0);
        chk("rst_valid",  32'(out_valid), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        apply(4'd3, 4'd5, 1'b0, 1'b1);
        chk("d_3p5_sum",  32'(sum),  32'd8);
        chk("d_3p5_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        chk("d_3p5_sum_q",  32'(sum_q),     32'd8);
        chk("d_3p5_cout_q", 32'(cout_q),    32'd0);
        chk("d_3p5_valid",  32'(out_valid), 32'd1);

        apply(4'd9, 4'd6, 1'b0, 1'b1);
        chk("d_9p6_sum",  32'(sum),  32'd15);
        chk("d_9p6_cout", 32'(cout), 32'd0);
        apply(4'd7, 4'd8, 1'b0, 1'b1);
        chk("d_7p8_sum",  32'(sum),  32'd15);
        chk("d_7p8_cout", 32'(cout), 32'd0);

        apply(4'd15, 4'd1, 1'b0, 1'b1);
        chk("d_wrap_sum",  32'(sum),  32'd0);
        chk("d_wrap_cout", 32'(cout), 32'd1);
        @(posedge clk); #1;
        chk("d_wrap_sum_q",  32'(sum_q),  32'd0);
        chk("d_wrap_cout_q", 32'(cout_q), 32'd1);

        apply(4'd10, 4'd3, 1'b1, 1'b1);
        chk("d_10p3c_sum",  32'(sum),  32'd14);
        chk("d_10p3c_cout", 32'(cout), 32'd0);
        apply(4'd15, 4'd15, 1'b1, 1'b1);
        chk("d_max_sum",  32'(sum),  32'd15);
        chk("d_max_cout", 32'(cout), 32'd1);
        @(posedge clk); #1;
        chk("d_max_sum_q",  32'(sum_q),  32'd15);
        chk("d_max_cout_q", 32'(cout_q), 32'd1);

        // Hold: registered copy must stay at 15/1 while operands change
        apply(4'd2, 4'd1, 1'b0, 1'b0);
        apply(4'd4, 4'd4, 1'b0, 1'b0);
        chk("d_hold_sum",    32'(sum),       32'd8);
        chk("d_hold_sum_q",  32'(sum_q),     32'd15);
        chk("d_hold_cout_q", 32'(cout_q),    32'd1);
        chk("d_hold_valid",  32'(out_valid), 32'd0);

        // Async reset between edges, with a capture pending
        apply(4'd6, 4'd5, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("d_arst_sum_q",  32'(sum_q),     32'd0);
        chk("d_arst_cout_q", 32'(cout_q),    32'd0);
        chk("d_arst_valid",  32'(out_valid), 32'd0);
        chk("d_arst_sum",    32'(sum),       32'd11);
        @(posedge clk); #1;
        chk("d_arst_hold_q", 32'(sum_q),     32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("d_post_rst_q",  32'(sum_q),     32'd11);
        chk("d_post_rst_v",  32'(out_valid), 32'd1);

`ifdef RCA_OVERFLOW_EN
        apply(4'd7, 4'd1, 1'b0, 1'b1);
        chk("d_ovf_7p1", 32'(ovf), 32'd1);
        apply(4'd8, 4'd8, 1'b0, 1'b1);
        chk("d_ovf_8p8", 32'(ovf), 32'd1);
        chk("d_ovf_8p8_cout", 32'(cout), 32'd1);
        apply(4'd3, 4'd2, 1'b0, 1'b1);
        chk("d_ovf_3p2", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] e;
            v = 9'(i);
            apply(v[3:0], v[7:4], v[8], v[0] ^ v[5]);
            e = ref_add(v[3:0], v[7:4], v[8]);
            chk("sweep_sum",  32'(sum),  32'(e[3:0]));
            chk("sweep_cout", 32'(cout), 32'(e[4]));
        end

        @(posedge clk); @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ripple_carry_adder_4bit

// File: doc/ripple_carry_adder_4bit.md
Name: ripple_carry_adder_4bit

Overview:
- Unsigned 4-bit ripple-carry adder: Sum/Cout = A + B + Cin, built from a chain of full-adder cells.
- Combinational result outputs settle within the same evaluation; no clock edge is needed for them.
- A one-cycle registered copy of the result, with a valid flag, lets clocked datapaths consume it.
- Used as a leaf arithmetic block in small datapaths and teaching benches.

Parameters:
- WIDTH, 4, operand/sum width; the chain has WIDTH full-adder cells. The only supported/verified value is 4; it is exposed for reuse.

Ports:
- clk    input   1      single clock; all registers on its rising edge
- rst    input   1      asynchronous, active-high reset
- A      input   WIDTH  operand A (unsigned)
- B      input   WIDTH  operand B (unsigned)
- Cin    input   1      carry into bit 0
- in_valid  input   1   qualifies A/B/Cin for the registered path
- Sum    output  WIDTH  combinational sum bits
- Cout   output  1      combinational carry out of MSB
- Sum_q  output  WIDTH  registered Sum
- Cout_q output  1      registered Cout
- out_valid output  1   registered in_valid

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Carry chain: c[0]=Cin. For each bit i: Sum[i]=A[i]^B[i]^c[i] and c[i+1]=(A[i]&B[i])|(B[i]&c[i])|(A[i]&c[i]). Cout=c[WIDTH].
- {Cout,Sum} equals the (WIDTH+1)-bit A+B+Cin exactly. There is no saturation; results wrap modulo 2^WIDTH, and the carry appears on Cout.
- Sum and Cout are purely combinational, have zero-cycle latency, and are unaffected by clk and rst.
- Registered path, latency 1: on each rising clk edge, if in_valid=1, Sum_q<=Sum and Cout_q<=Cout. If in_valid=0, Sum_q and Cout_q hold their values.
- out_valid<=in_valid on every rising edge.
- Reset: while rst=1, Sum_q=0, Cout_q=0 and out_valid=0 immediately, with no clock needed.
- Reset deassertion: the first capture happens on the first rising edge after rst falls.
- Reset mid-operation: a pending capture is discarded. Combinational outputs keep tracking the inputs.
- X/Z on inputs propagates naturally. No internal state other than the three registers.

Optional Feature:
- Macro RCA_OVERFLOW_EN.
- When defined, adds output Ovf (1 bit, combinational) = c[WIDTH]^c[WIDTH-1], the two's-complement signed overflow.
- It also adds Ovf_q, registered under the same in_valid/reset rules as Sum_q, with reset value 0.
- When undefined, neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Shared package rca_pkg:
  - constant RCA_DEFAULT_WIDTH=4
  - typedef operand_t = logic [RCA_DEFAULT_WIDTH-1:0]
- One natural sub-module: rca_full_adder (inputs a, b, cin; outputs sum, cout). It is instantiated WIDTH times via generate, with carries chained LSB to MSB.

Test Plan:
- A=3, B=5, Cin=0 -> Sum=8, Cout=0; after a clk edge with in_valid=1 -> Sum_q=8, Cout_q=0, out_valid=1.
- A=9, B=6, Cin=0 -> Sum=15, Cout=0; A=7, B=8, Cin=0 -> Sum=15, Cout=0 (full propagate, no carry).
- A=15, B=1, Cin=0 -> Sum=0, Cout=1 (wrap-around, carry ripples through all bits); registered copy is 0/1 one cycle later.
- A=10, B=3, Cin=1 -> Sum=14, Cout=0; A=15, B=15, Cin=1 -> Sum=15, Cout=1 (maximum value).
- Registered path: hold in_valid=0 while changing A/B -> Sum_q unchanged, out_valid=0. Assert rst asynchronously between edges -> Sum_q=0, Cout_q=0, out_valid=0 at once, while Sum still tracks the inputs.
- With RCA_OVERFLOW_EN: A=7, B=1, Cin=0 -> Ovf=1; A=8, B=8 -> Ovf=1, Cout=1; A=3, B=2 -> Ovf=0.
- Exhaustive sweep: all 512 A/B/Cin combinations compared against the reference sum A+B+Cin.
